// File: rtl/apuf_arbiter_sampler_if.sv
// rtl/apuf_arbiter_sampler_if.sv - challenge/response and delay-chain signal bundle for the arbiter-PUF sampler
interface apuf_arbiter_sampler_if #(
  parameter int STAGES = 64,
  parameter int CW     = 3
);
  // challenge side
  logic [STAGES-1:0] chal_in;
  logic              chal_valid;
  logic              chal_ready;

  // delay-chain side
  logic [STAGES-1:0] chal_out;
  logic              launch;
  logic              arb_clr;
  logic              arb_in;

  // response side
  logic              resp_out;
  logic [CW-1:0]     resp_conf;
  logic              resp_valid;
  logic              resp_ready;

  logic              busy;

  // environment / stimulus side
  modport master (
    output chal_in, chal_valid, arb_in, resp_ready,
    input  chal_ready, chal_out, launch, arb_clr,
           resp_out, resp_conf, resp_valid, busy
  );

  // sampler side
  modport slave (
    input  chal_in, chal_valid, arb_in, resp_ready,
    output chal_ready, chal_out, launch, arb_clr,
           resp_out, resp_conf, resp_valid, busy
  );
endinterface

// File: rtl/apuf_arbiter_sampler.sv
// rtl/apuf_arbiter_sampler.sv - arbiter-PUF challenge sequencer with majority-voted response
module apuf_arbiter_sampler #(
  parameter int STAGES = 64,
  parameter int SETTLE = 16,
  parameter int VOTES  = 7,
  parameter int CW     = $clog2(VOTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  apuf_arbiter_sampler_if.slave bus
);

  localparam int PW = $clog2(SETTLE + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(SETTLE - 1);
  localparam logic [CW-1:0] VOTES_C = CW'(VOTES);
  localparam logic [CW-1:0] HALF_C  = CW'(VOTES / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FIRE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_phase;
  logic [CW-1:0]     r_ones;
  logic [CW-1:0]     r_trial;
  logic [STAGES-1:0] r_chal;
  logic              r_launch;
  logic              r_clr;
  logic              r_resp;
  logic [CW-1:0]     r_conf;
  logic              r_valid;
  logic              r_sync1;
  logic              r_sync2;

  logic [CW-1:0]     w_ones_next;
  logic [CW-1:0]     w_trial_next;

  // vote and trial counts as they will be after the current sample is folded in
  assign w_ones_next  = r_ones + CW'(r_sync2);
  assign w_trial_next = r_trial + CW'(1);

  // arb_in is launched by the chain, not by clk: two flops tame metastability before any decision uses it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.arb_in;
      r_sync2 <= r_sync1;
    end
  end

  // trial sequencer: clear the arbiter, launch the edge, sample, repeat VOTES times, then hand back the vote
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_ones   <= '0;
      r_trial  <= '0;
      r_chal   <= '0;
      r_launch <= 1'b0;
      r_clr    <= 1'b0;
      r_resp   <= 1'b0;
      r_conf   <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.chal_valid) begin
            r_chal  <= bus.chal_in;
            r_ones  <= '0;
            r_trial <= '0;
            r_phase <= '0;
            r_clr   <= 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (r_phase == PH_LAST) begin
            r_phase  <= '0;
            r_clr    <= 1'b0;
            r_launch <= 1'b1;
            r_state  <= S_FIRE;
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        S_FIRE: begin
          // launch stays high through SAMPLE so the edge is still in flight while the decision is read
          if (r_phase == PH_LAST) begin
            r_phase <= '0;
            r_state <= S_SAMPLE;
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        S_SAMPLE: begin
          r_ones   <= w_ones_next;
          r_trial  <= w_trial_next;
          r_launch <= 1'b0;
          if (w_trial_next == VOTES_C) begin
            r_valid <= 1'b1;
            r_resp  <= (w_ones_next > HALF_C);
            r_conf  <= w_ones_next;
            r_state <= S_DONE;
          end else begin
            r_clr   <= 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_DONE: begin
          if (bus.resp_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_launch <= 1'b0;
          r_clr    <= 1'b0;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.chal_ready = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.chal_out   = r_chal;
  assign bus.launch     = r_launch;
  assign bus.arb_clr    = r_clr;
  assign bus.resp_out   = r_resp;
  assign bus.resp_conf  = r_conf;
  assign bus.resp_valid = r_valid;

endmodule

// File: tb/tb_apuf_arbiter_sampler.sv
// tb/tb_apuf_arbiter_sampler.sv - self-checking bench for apuf_arbiter_sampler
module tb_apuf_arbiter_sampler;

  localparam int STAGES = 8;
  localparam int SETTLE = 4;
  localparam int VOTES  = 3;
  localparam int CW     = 2;
  localparam int P      = 2 * SETTLE + 1;
  localparam int T      = VOTES * P;

  logic clk;
  logic rst_n;

  apuf_arbiter_sampler_if #(.STAGES(STAGES), .CW(CW)) dif();

  apuf_arbiter_sampler #(
    .STAGES(STAGES), .SETTLE(SETTLE), .VOTES(VOTES), .CW(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // behavioural model: a transaction is k cycles old; every trial spans P cycles
  bit         m_idle = 1'b1;
  int         m_k = 0;
  int         m_ones = 0;
  logic [7:0] m_chal = '0;
  bit         m_resp = 1'b0;
  int         m_conf = 0;
  bit         m_acc = 1'b0;
  int         m_acc_cyc = 0;
  int         cyc = 0;
  bit         chk_en = 1'b0;
  int         n_launch = 0;
  int         n_clr = 0;

  always @(posedge clk) begin
    cyc++;
    chk_en = 1'b1;
    if (!rst_n) begin
      m_idle = 1'b1;
      m_chal = '0;
      m_resp = 1'b0;
      m_conf = 0;
      m_k    = 0;
    end else if (m_idle) begin
      if (dif.chal_valid) begin
        m_idle    = 1'b0;
        m_chal    = dif.chal_in;
        m_k       = 0;
        m_ones    = 0;
        m_acc     = 1'b1;
        m_acc_cyc = cyc;
        n_launch  = 0;
        n_clr     = 0;
      end
    end else if (m_k == T) begin
      if (dif.resp_ready) m_idle = 1'b1;
    end else begin
      if (m_k % P == 2 * SETTLE) m_ones += int'(dif.arb_in);
      m_k++;
      if (m_k == T) begin
        m_resp = (m_ones > VOTES / 2);
        m_conf = m_ones;
      end
    end
  end

  // compare every output against the model on every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      bit act_trial;
      int pos;
      act_trial = !m_idle && (m_k < T);
      pos = m_k % P;
      chk("chal_ready", 32'(dif.chal_ready), 32'(m_idle));
      chk("busy",       32'(dif.busy),       32'(!m_idle));
      chk("chal_out",   32'(dif.chal_out),   32'(m_chal));
      chk("launch",     32'(dif.launch),     32'(act_trial && pos >= SETTLE));
      chk("arb_clr",    32'(dif.arb_clr),    32'(act_trial && pos < SETTLE));
      chk("resp_valid", 32'(dif.resp_valid), 32'(!m_idle && m_k == T));
      chk("resp_out",   32'(dif.resp_out),   32'(m_resp));
      chk("resp_conf",  32'(dif.resp_conf),  32'(m_conf));
      chk("overlap",    32'(dif.launch && dif.arb_clr), 32'd0);
      if (dif.launch === 1'b1) n_launch++;
      if (dif.arb_clr === 1'b1) n_clr++;
    end
  end

  // arb_in driver: per-trial vote from v_pat, held from the first FIRE cycle; optional noise during CLEAR
  logic [VOTES-1:0] v_pat = '0;
  bit               v_tog = 1'b0;

  initial begin
    dif.arb_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!m_idle && m_k < T) begin
        int pos;
        int tr;
        pos = m_k % P;
        tr  = m_k / P;
        if (pos >= SETTLE || !v_tog) dif.arb_in = v_pat[tr];
        else if (pos == SETTLE - 1) dif.arb_in = 1'b1;
        else dif.arb_in = 1'($urandom_range(0, 1));
      end
    end
  end

  logic [7:0] acc_chal_out;

  task automatic start_txn(input logic [7:0] c);
    dif.chal_in    = c;
    dif.chal_valid = 1'b1;
    m_acc          = 1'b0;
    begin : acc_wait
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (m_acc) disable acc_wait;
      end
      timeout("accept");
    end
    acc_chal_out   = dif.chal_out;
    dif.chal_valid = 1'b0;
  endtask

  task automatic finish_txn(input int bp, output bit ro, output int rc, output int lat);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (dif.resp_valid === 1'b1) got = 1'b1;
    end
    if (!got) timeout("resp_valid");
    lat = cyc - m_acc_cyc;
    ro  = dif.resp_out;
    rc  = int'(dif.resp_conf);
    repeat (bp) @(negedge clk);
    #1;
    dif.resp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [7:0] c, input logic [VOTES-1:0] pat, input bit tog,
                         input int bp, output bit ro, output int rc, output int lat);
    v_pat          = pat;
    v_tog          = tog;
    dif.resp_ready = (bp == 0);
    start_txn(c);
    finish_txn(bp, ro, rc, lat);
  endtask

  bit ro;
  int rc;
  int lat;

  initial begin
    rst_n          = 1'b0;
    dif.chal_in    = 8'h77;
    dif.chal_valid = 1'b1;
    dif.resp_ready = 1'b1;

    // reset with chal_valid asserted
    repeat (3) @(posedge clk);
    #1;
    chk("rst_launch",     32'(dif.launch), 32'd0);
    chk("rst_arb_clr",    32'(dif.arb_clr), 32'd0);
    chk("rst_chal_out",   32'(dif.chal_out), 32'd0);
    chk("rst_resp_valid", 32'(dif.resp_valid), 32'd0);
    chk("rst_busy",       32'(dif.busy), 32'd0);
    dif.chal_valid = 1'b0;
    rst_n          = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_chal_ready", 32'(dif.chal_ready), 32'd1);
    chk("post_rst_busy",       32'(dif.busy), 32'd0);

    // basic evaluation, arb_in constantly 1
    run_txn(8'hA5, 3'b111, 1'b0, 0, ro, rc, lat);
    chk("basic_chal_out", 32'(acc_chal_out), 32'hA5);
    chk("basic_latency",  32'(lat), 32'd27);
    chk("basic_resp",     32'(ro), 32'd1);
    chk("basic_conf",     32'(rc), 32'd3);
    chk("basic_launch_cycles", 32'(n_launch), 32'd15);
    chk("basic_clr_cycles",    32'(n_clr), 32'd12);

    // majority votes; pattern bit i is trial i
    run_txn(8'h11, 3'b101, 1'b0, 0, ro, rc, lat);
    chk("vote101_resp", 32'(ro), 32'd1);
    chk("vote101_conf", 32'(rc), 32'd2);
    run_txn(8'h22, 3'b010, 1'b0, 0, ro, rc, lat);
    chk("vote010_resp", 32'(ro), 32'd0);
    chk("vote010_conf", 32'(rc), 32'd1);
    run_txn(8'h33, 3'b000, 1'b0, 0, ro, rc, lat);
    chk("vote000_resp", 32'(ro), 32'd0);
    chk("vote000_conf", 32'(rc), 32'd0);

    // arb_in noisy during CLEAR (ending high), held 0 through FIRE
    run_txn(8'h5A, 3'b000, 1'b1, 0, ro, rc, lat);
    chk("async_resp", 32'(ro), 32'd0);
    chk("async_conf", 32'(rc), 32'd0);

    // backpressure with a pending challenge
    v_pat          = 3'b111;
    v_tog          = 1'b0;
    dif.resp_ready = 1'b0;
    start_txn(8'hA5);
    begin : bp_wait
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (dif.resp_valid === 1'b1) disable bp_wait;
      end
      timeout("bp_resp_valid");
    end
    #1;
    dif.chal_in    = 8'h3C;
    dif.chal_valid = 1'b1;
    m_acc          = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_hold",  32'(dif.resp_valid), 32'd1);
      chk("bp_resp_hold",   32'(dif.resp_out), 32'd1);
      chk("bp_conf_hold",   32'(dif.resp_conf), 32'd3);
      chk("bp_chal_ready",  32'(dif.chal_ready), 32'd0);
      chk("bp_chal_out",    32'(dif.chal_out), 32'hA5);
    end
    #1;
    dif.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready",  32'(dif.chal_ready), 32'd1);
    chk("bp_idle_valid",  32'(dif.resp_valid), 32'd0);
    chk("bp_idle_chal",   32'(dif.chal_out), 32'hA5);
    @(negedge clk);
    chk("bp_next_chal",   32'(dif.chal_out), 32'h3C);
    chk("bp_next_busy",   32'(dif.busy), 32'd1);
    #1;
    dif.chal_valid = 1'b0;
    finish_txn(0, ro, rc, lat);
    chk("bp_next_conf", 32'(rc), 32'd3);

    // reset during the FIRE phase of trial 2
    v_pat = 3'b101;
    start_txn(8'hA5);
    begin : mr_wait
      for (int i = 0; i < 100; i++) begin
        if (!m_idle && m_k == P + SETTLE + 1) disable mr_wait;
        @(posedge clk);
        #1;
      end
      timeout("midrst_reach_fire");
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_launch",   32'(dif.launch), 32'd0);
    chk("midrst_chal_out", 32'(dif.chal_out), 32'd0);
    chk("midrst_busy",     32'(dif.busy), 32'd0);
    chk("midrst_valid",    32'(dif.resp_valid), 32'd0);
    run_txn(8'hFF, 3'b111, 1'b0, 0, ro, rc, lat);
    chk("midrst_after_latency", 32'(lat), 32'd27);
    chk("midrst_after_resp",    32'(ro), 32'd1);
    chk("midrst_after_conf",    32'(rc), 32'd3);

    // randomized transactions, checked by the per-cycle model
    for (int n = 0; n < 25; n++) begin
      run_txn(8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), ro, rc, lat);
      chk("rand_latency", 32'(lat), 32'd27);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
